fft_frame_sequencer: RTL

//   Sequences the 8-point radix-2 pipelined FFT datapath from a single clock.
//   - Collects N serial samples into a frame and presents it in parallel on dp_in.
//   - Steps the datapath stage enables, waits out its latency, then captures dp_out.
//   - Streams the N results out with a valid/ready handshake.
//   - Sits between the sample source and the datapath. One frame in flight at a time.

---
 rtl/fft_frame_sequencer_if.sv | 26 ++
 rtl/fft_frame_sequencer.sv | 137 +++++++++++++
 2 files changed

// File: rtl/fft_frame_sequencer_if.sv
// Sample-in and result-out handshake bundle for the FFT frame sequencer.
// master = the sequencer itself, slave = the surrounding source/consumer.
interface fft_frame_sequencer_if #(
  parameter int DATA_W = 8,
  parameter int OUT_W  = 8,
  parameter int IDX_W  = 3
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_data;
  logic              m_valid;
  logic              m_ready;
  logic [OUT_W-1:0]  m_data;
  logic [IDX_W-1:0]  m_index;
  logic              m_last;

  modport master (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_index, m_last
  );

  modport slave (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_index, m_last
  );
endinterface

// File: rtl/fft_frame_sequencer.sv
// Frames serial samples for an 8-point pipelined FFT datapath, steps its stage
// enables, captures the results after the datapath latency and streams them out.
module fft_frame_sequencer #(
  parameter int DATA_W   = 8,
  parameter int OUT_W    = 8,
  parameter int N_POINTS = 8,
  parameter int STAGES   = 3,
  parameter int LAT      = 3,
  parameter int BITREV   = 0
) (
  input  logic                         clk,
  input  logic                         rst_n,
  fft_frame_sequencer_if.master        bus,
  output logic [N_POINTS*DATA_W-1:0]   dp_in,
  output logic [STAGES-1:0]            dp_stage_en,
  input  logic [N_POINTS*OUT_W-1:0]    dp_out,
  output logic                         busy,
  output logic [15:0]                  frame_cnt
);
  // state    | meaning
  // IDLE     | no frame in flight, waiting for the first sample
  // LOAD     | collecting samples into dp_in
  // RUN      | stepping the one-hot stage enables, one stage per cycle
  // WAIT     | waiting out the datapath latency (skipped when LAT = 0)
  // DRAIN    | streaming captured results to the consumer
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_LOAD  = 3'd1;
  localparam logic [2:0] ST_RUN   = 3'd2;
  localparam logic [2:0] ST_WAIT  = 3'd3;
  localparam logic [2:0] ST_DRAIN = 3'd4;

  localparam int IDX_W  = $clog2(N_POINTS);
  localparam int TMR_W  = (LAT > 1) ? $clog2(LAT) : 1;
  localparam int LAT_M1 = (LAT > 0) ? LAT - 1 : 0;

  logic [2:0]       state;
  logic [IDX_W-1:0] wr_cnt;
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] slot;
  logic [TMR_W-1:0] wait_tmr;
  logic [OUT_W-1:0] result [N_POINTS];
  logic             s_hs;
  logic             m_hs;
  logic             capture;

  function automatic logic [IDX_W-1:0] bit_rev(input logic [IDX_W-1:0] v);
    logic [IDX_W-1:0] r;
    r = '0;
    for (int b = 0; b < IDX_W; b++) r[b] = v[IDX_W-1-b];
    return r;
  endfunction

  always_comb begin
    bus.s_ready = (state == ST_IDLE) || (state == ST_LOAD);
    bus.m_valid = (state == ST_DRAIN);
    busy        = (state != ST_IDLE);
    slot        = (BITREV != 0) ? bit_rev(rd_idx) : rd_idx;
    bus.m_index = rd_idx;
    bus.m_data  = bus.m_valid ? result[slot] : '0;
    bus.m_last  = bus.m_valid && (rd_idx == IDX_W'(N_POINTS - 1));
    s_hs        = bus.s_valid & bus.s_ready;
    m_hs        = bus.m_valid & bus.m_ready;
  end

  // Results are latched at the end of the last RUN cycle (LAT = 0) or last WAIT cycle.
  always_comb begin
    capture = 1'b0;
    if (LAT == 0)
      capture = (state == ST_RUN) && dp_stage_en[STAGES-1];
    else
      capture = (state == ST_WAIT) && (wait_tmr == '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      wr_cnt      <= '0;
      rd_idx      <= '0;
      wait_tmr    <= '0;
      dp_in       <= '0;
      dp_stage_en <= '0;
      frame_cnt   <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_LOAD: begin
          if (s_hs) begin
            for (int k = 0; k < N_POINTS; k++)
              if (wr_cnt == IDX_W'(k)) dp_in[k*DATA_W +: DATA_W] <= bus.s_data;
            if (wr_cnt == IDX_W'(N_POINTS - 1)) begin
              wr_cnt      <= '0;
              state       <= ST_RUN;
              dp_stage_en <= STAGES'(1);
            end else begin
              wr_cnt <= wr_cnt + 1'b1;
              state  <= ST_LOAD;
            end
          end
        end
        ST_RUN: begin
          dp_stage_en <= dp_stage_en << 1;
          if (dp_stage_en[STAGES-1]) begin
            if (LAT == 0) begin
              state <= ST_DRAIN;
            end else begin
              state    <= ST_WAIT;
              wait_tmr <= TMR_W'(LAT_M1);
            end
          end
        end
        ST_WAIT: begin
          if (wait_tmr == '0) state <= ST_DRAIN;
          else                wait_tmr <= wait_tmr - 1'b1;
        end
        ST_DRAIN: begin
          if (m_hs) begin
            if (bus.m_last) begin
              rd_idx    <= '0;
              state     <= ST_IDLE;
              frame_cnt <= frame_cnt + 16'd1;
            end else begin
              rd_idx <= rd_idx + 1'b1;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < N_POINTS; k++) result[k] <= '0;
    end else if (capture) begin
      for (int k = 0; k < N_POINTS; k++) result[k] <= dp_out[k*OUT_W +: OUT_W];
    end
  end
endmodule
